// File: rtl/dualram_pkg.sv
// ============================================================================
// Module   : dualram_pkg
// Brief    : Shared types, constants and the address range helper for dualram_be.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dualram_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    RUN_PEND = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam int unsigned DEF_BASE = 206800;

  // 64-bit arithmetic keeps addresses below base from wrapping into range
  function automatic logic range_ok(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth);
    return (addr >= base) && ((addr - base) < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dualram_port.sv
// ============================================================================
// Module   : dualram_port
// Brief    : One RAM port: range check, array index, registered rdata/rvalid/err.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dualram_port
  import dualram_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 204900,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BASE   = DEF_BASE,
  parameter int unsigned IDX_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_rd_word,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_in_range,
  output logic              o_wr_en,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_rvalid,
  output logic              o_err
);

  logic [ADDR_W-1:0] w_off;

  assign o_in_range = range_ok(64'(i_addr), 64'(BASE), 64'(DEPTH));
  assign w_off      = i_addr - ADDR_W'(BASE);
  assign o_idx      = IDX_W'(w_off);
  assign o_wr_en    = i_accept && i_we && o_in_range;

  // rdata holds across writes and idle cycles; out-of-range accesses zero it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_rvalid <= i_accept;
      o_err    <= i_accept && !o_in_range;
      if (i_accept) begin
        if (!o_in_range) begin
          o_rdata <= '0;
        end else if (!i_we) begin
          o_rdata <= i_rd_word;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dualram_be.sv
// ============================================================================
// Module   : dualram_be
// Brief    : Dual-port byte-enable SRAM with range errors and post-reset clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dualram_be
  import dualram_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 204900,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BASE           = DEF_BASE,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [WIDTH/8-1:0]   be1,
  input  logic [ADDR_W-1:0]    address1,
  input  logic [WIDTH-1:0]     wdata1,
  output logic [WIDTH-1:0]     rdata1,
  output logic                 rvalid1,
  output logic                 err1,
  input  logic                 req2,
  input  logic                 we2,
  input  logic [WIDTH/8-1:0]   be2,
  input  logic [ADDR_W-1:0]    address2,
  input  logic [WIDTH-1:0]     wdata2,
  output logic [WIDTH-1:0]     rdata2,
  output logic                 rvalid2,
  output logic                 err2
);

  localparam int unsigned NB       = WIDTH / 8;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam state_t      RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN_PEND;

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;

  logic             w_acc1, w_acc2;
  logic [IDX_W-1:0] w_idx1, w_idx2;
  logic             w_rng1, w_rng2;
  logic             w_wr1,  w_wr2;
  logic [WIDTH-1:0] w_rd1,  w_rd2;

  assign ready  = (r_state == RUN);
  assign w_acc1 = req1 && ready;
  assign w_acc2 = req2 && ready;
  assign w_rd1  = w_rng1 ? r_mem[w_idx1] : '0;
  assign w_rd2  = w_rng2 ? r_mem[w_idx2] : '0;

  dualram_port #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .BASE (BASE), .IDX_W (IDX_W)
  ) u_port1 (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_acc1),
    .i_we       (we1),
    .i_addr     (address1),
    .i_rd_word  (w_rd1),
    .o_idx      (w_idx1),
    .o_in_range (w_rng1),
    .o_wr_en    (w_wr1),
    .o_rdata    (rdata1),
    .o_rvalid   (rvalid1),
    .o_err      (err1)
  );

  dualram_port #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .BASE (BASE), .IDX_W (IDX_W)
  ) u_port2 (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_acc2),
    .i_we       (we2),
    .i_addr     (address2),
    .i_rd_word  (w_rd2),
    .o_idx      (w_idx2),
    .o_in_range (w_rng2),
    .o_wr_en    (w_wr2),
    .o_rdata    (rdata2),
    .o_rvalid   (rvalid2),
    .o_err      (err2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:    if (r_cnt == LAST_IDX) w_state_nxt = RUN;
      RUN_PEND: w_state_nxt = RUN;
      RUN:      w_state_nxt = RUN;
      default:  w_state_nxt = RST_STATE;
    endcase
  end

  // Port 1 lanes are assigned last so they win a same-index write collision
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_wr2 && be2[b]) r_mem[w_idx2][8*b +: 8] <= wdata2[8*b +: 8];
        if (w_wr1 && be1[b]) r_mem[w_idx1][8*b +: 8] <= wdata1[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dualram_be.sv
// ============================================================================
// Module   : tb_dualram_be
// Brief    : Directed self-checking bench for dualram_be (DEPTH=16, clear on reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dualram_be;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] B     = 32'd206800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready;
  logic        req1 = 1'b0, we1 = 1'b0, req2 = 1'b0, we2 = 1'b0;
  logic [3:0]  be1 = '0, be2 = '0;
  logic [31:0] address1 = '0, address2 = '0, wdata1 = '0, wdata2 = '0;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2, err1, err2;

  int checks   = 0;
  int failures = 0;

  dualram_be #(
    .WIDTH (32), .DEPTH (DEPTH), .ADDR_W (32), .BASE (206800), .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .ready (ready),
    .req1 (req1), .we1 (we1), .be1 (be1), .address1 (address1), .wdata1 (wdata1),
    .rdata1 (rdata1), .rvalid1 (rvalid1), .err1 (err1),
    .req2 (req2), .we2 (we2), .be2 (be2), .address2 (address2), .wdata2 (wdata2),
    .rdata2 (rdata2), .rvalid2 (rvalid2), .err2 (err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p1(input logic r, input logic w, input logic [31:0] a,
                    input logic [3:0] b, input logic [31:0] d);
    req1 = r; we1 = w; address1 = a; be1 = b; wdata1 = d;
  endtask

  task automatic p2(input logic r, input logic w, input logic [31:0] a,
                    input logic [3:0] b, input logic [31:0] d);
    req2 = r; we2 = w; address2 = a; be2 = b; wdata2 = d;
  endtask

  // Release reset and count cycles until ready, with a read held on port 1
  task automatic release_and_count(input string tag);
    int   n;
    logic saw;
    n   = 0;
    saw = 1'b0;
    p1(1'b1, 1'b0, B + 32'd1, 4'h0, 32'h0);
    rst = 1'b0;
    while (!ready && n < 40) begin
      tick();
      n++;
      if (rvalid1 || err1) saw = 1'b1;
    end
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check({tag, "_clear_cycles"}, 32'(n), 32'd16);
    check({tag, "_ignored_req"}, 32'(saw), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_ready",   32'(ready),   32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_err2",    32'(err2),    32'd0);
    check("rst_rdata1",  rdata1,       32'h0);
    tick();
    #1;
    release_and_count("init");

    // Cleared word reads back zero, latency one
    p1(1'b1, 1'b0, B + 32'd5, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("clr_rd_rvalid", 32'(rvalid1), 32'd1);
    check("clr_rd_err",    32'(err1),    32'd0);
    check("clr_rd_data",   rdata1,       32'h0);

    // Byte enables
    p1(1'b1, 1'b1, B + 32'd3, 4'hF, 32'hAABBCCDD);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("be_wr_ack",   32'(rvalid1), 32'd1);
    check("be_wr_rdata", rdata1,       32'h0);
    p2(1'b1, 1'b1, B + 32'd3, 4'h5, 32'h11223344);
    tick();
    p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("be_wr2_ack", 32'(rvalid2), 32'd1);
    p1(1'b1, 1'b0, B + 32'd3, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("be_merge", rdata1, 32'hAA22CC44);

    // Write/write collision
    p1(1'b1, 1'b1, B + 32'd7, 4'h1, 32'h000000FF);
    p2(1'b1, 1'b1, B + 32'd7, 4'hF, 32'h12345678);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    p1(1'b1, 1'b0, B + 32'd7, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("ww_collision", rdata1, 32'h123456FF);

    // Read-first
    p1(1'b1, 1'b1, B + 32'd2, 4'hF, 32'h5);
    tick();
    p1(1'b1, 1'b1, B + 32'd2, 4'hF, 32'h9);
    p2(1'b1, 1'b0, B + 32'd2, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("rf_old_data", rdata2, 32'h5);
    check("rf_rvalid2",  32'(rvalid2), 32'd1);
    tick();
    p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("rf_new_data", rdata2, 32'h9);

    // Idle: pulses drop, rdata holds
    tick();
    check("idle_rvalid2", 32'(rvalid2), 32'd0);
    check("idle_hold2",   rdata2,       32'h9);

    // Out of range on both ports
    p1(1'b1, 1'b0, B - 32'd1, 4'h0, 32'h0);
    p2(1'b1, 1'b1, B + DEPTH, 4'hF, 32'hDEADBEEF);
    tick();
    check("oor1_rvalid", 32'(rvalid1), 32'd1);
    check("oor1_err",    32'(err1),    32'd1);
    check("oor1_rdata",  rdata1,       32'h0);
    check("oor2_rvalid", 32'(rvalid2), 32'd1);
    check("oor2_err",    32'(err2),    32'd1);
    check("oor2_rdata",  rdata2,       32'h0);
    p1(1'b1, 1'b1, B + DEPTH, 4'hF, 32'hCAFEF00D);
    p2(1'b1, 1'b1, B - 32'd1, 4'hF, 32'h55AA55AA);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("oor_wr1_err", 32'(err1), 32'd1);
    check("oor_wr2_err", 32'(err2), 32'd1);
    tick();
    check("oor_err_drop", 32'(err1), 32'd0);
    p1(1'b1, 1'b0, B + DEPTH - 32'd1, 4'h0, 32'h0);
    p2(1'b1, 1'b0, B, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("top_word_err",   32'(err1), 32'd0);
    check("top_word_data",  rdata1,    32'h0);
    check("bot_word_data",  rdata2,    32'h0);
    check("bot_word_valid", 32'(rvalid2), 32'd1);

    // Async reset drops an in-flight response
    p1(1'b1, 1'b0, B + DEPTH, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("pre_rst_rvalid", 32'(rvalid1), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rvalid", 32'(rvalid1), 32'd0);
    check("async_err",    32'(err1),    32'd0);
    check("async_ready",  32'(ready),   32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_clear_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid1), 32'd0);
    check("mid_rst_ready",  32'(ready),   32'd0);
    #1;
    release_and_count("restart");

    // Clear wiped earlier writes
    p1(1'b1, 1'b0, B + 32'd3, 4'h0, 32'h0);
    p2(1'b1, 1'b0, B + 32'd7, 4'h0, 32'h0);
    tick();
    p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    p2(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("wiped_3", rdata1, 32'h0);
    check("wiped_7", rdata2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dualram_be.md
Name: dualram_be

Overview:
- Parametrised successor to the team's synchronous dual-port SRAM.
- Two symmetric word-addressed ports on one clock, with per-byte write enables, registered (1-cycle) reads and a valid strobe.
- Out-of-range detection, defined collision rules, and an optional post-reset clear sequencer that zero-fills the array.
- Sits between the CPU data bus / JPEG DMA and the shared image buffer.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 204900, number of words.
- ADDR_W, 32, address width.
- BASE, 206800, word address mapped to memory index 0.
- CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset before accepting requests.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high when requests are accepted.
- req1 / req2  in  1  port request.
- we1 / we2  in  1  1 = write, 0 = read.
- be1 / be2  in  WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i].
- address1 / address2  in  ADDR_W  word address; index = address-BASE.
- wdata1 / wdata2  in  WIDTH  write data.
- rdata1 / rdata2  out  WIDTH  registered read data.
- rvalid1 / rvalid2  out  1  one-cycle pulse: rdata valid, or write acknowledged.
- err1 / err2  out  1  one-cycle pulse with rvalid: address out of range.

Behaviour:
- Reset (async assert): ready=0, rdata*=0, rvalid*=0, err*=0, clear counter=0, FSM->CLEAR if CLEAR_ON_RESET else RUN_PEND.
- Reset mid-operation: in-flight responses are dropped and the clear restarts from index 0.
- Array contents are not reset when CLEAR_ON_RESET=0.
- FSM CLEAR:
  - Writes 0 to index cnt each cycle; cnt++.
  - At cnt==DEPTH-1, writes the last word and moves to RUN; ready=1 from the next cycle.
  - Clear lasts exactly DEPTH cycles after reset release.
- FSM RUN_PEND (CLEAR_ON_RESET=0): one cycle, then RUN. ready rises on the first edge after reset release.
- FSM RUN: ready=1; no exit except reset.
- Accepting requests:
  - A request is accepted when req && ready at a rising edge; no back-pressure otherwise.
  - Requests while ready=0 are ignored: no rvalid, no write.
- Range check: in_range = (address >= BASE) && (address-BASE < DEPTH), computed in ADDR_W+1 bits so there is no wrap below BASE.
- Read (we=0), in range: rdata <= mem[idx] at the accept edge; rvalid=1 the next cycle. Latency 1.
- Write (we=1), in range: byte lanes with be[i]=1 are updated; other lanes unchanged. rvalid=1 the next cycle; rdata holds its previous value.
- be=0 write: no change, still acknowledged.
- Out of range, read or write: no array access, rdata<=0, rvalid=1, err=1 the next cycle.
- Read/write collision, same cycle: read-first. A read of a word being written by either port returns the old data.
- Write/write collision, same index: lanes enabled on port 1 take wdata1; lanes enabled only on port 2 take wdata2. Port 1 has priority.
- Idle ports: rvalid/err return to 0; rdata holds its last value.
- Back-to-back accesses on every cycle are supported on both ports: throughput 1 per port per cycle.

Decomposition:
- dualram_pkg:
  - typedef enum {CLEAR, RUN_PEND, RUN} state_t.
  - Constant DEF_BASE = 206800.
  - Function range_ok(addr, base, depth).
- Sub-module dualram_port: range check, index generation and output registers (rdata/rvalid/err). Instantiated twice.
- Top level: array, byte-lane write merge with port-1 priority, clear FSM.

Test Plan:
- Clear: DEPTH=16, CLEAR_ON_RESET=1, release rst. ready is 0 for 16 cycles then 1; reading address BASE+5 returns 0x00000000 with rvalid one cycle later.
- Byte enables: write1 BASE+3 = 0xAABBCCDD, be=1111; then write2 BASE+3 = 0x11223344, be=0101. Read1 returns 0xAA22CC44.
- Write/write collision: same cycle, port1 writes 0x000000FF with be=0001 and port2 writes 0x12345678 with be=1111 to BASE+7. Read gives 0x123456FF.
- Read-first: mem[BASE+2]=0x5; port1 writes 0x9 while port2 reads BASE+2 in the same cycle. rdata2=0x5; the next read gives 0x9.
- Range: address BASE-1, then BASE+DEPTH, on both ports. rvalid=1, err=1, rdata=0, no array change; BASE+DEPTH-1 gives err=0.
- Reset during clear at cnt=8: rvalid/err are 0 immediately; after release, clear takes the full 16 cycles again; requests with ready=0 produce no rvalid.
